// File: rtl/ctrl_reg_bridge.sv
// Queues load/store requests and issues them one at a time on the control-register port.
// SPI/GPIO accesses wait for the I/O sequencer. CTRL_REG_BRIDGE_TIMEOUT_EN adds a wait timeout.
module ctrl_reg_bridge #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [3:0]  i_req_wmask,
   input  logic [5:0]  i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [5:0]  i_req_tag,
   output logic        o_cr_ce_n,
   output logic        o_cr_we_n,
   output logic [3:0]  o_cr_wm,
   output logic [5:0]  o_cr_addr,
   output logic [31:0] o_cr_wdata,
   input  logic [31:0] i_cr_rdata,
   input  logic        i_cr_io_busy,
   output logic        o_rsp_valid,
   output logic [5:0]  o_rsp_tag,
   output logic [31:0] o_rsp_data,
   output logic        o_rsp_err
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned EW = 49;

   typedef enum logic [2:0] {StIdle, StWaitIo, StIssue, StRd1, StRd2} state_e;

   state_e        r_state;
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_req_ready;

   logic          r_cr_ce_n;
   logic          r_cr_we_n;
   logic [3:0]    r_cr_wm;
   logic [5:0]    r_cr_addr;
   logic [31:0]   r_cr_wdata;
   logic          r_rsp_valid;
   logic [5:0]    r_rsp_tag;
   logic [31:0]   r_rsp_data;
   logic          r_cur_we;
   logic [5:0]    r_cur_tag;

   logic [EW-1:0] w_head;
   logic          w_head_we;
   logic [3:0]    w_head_wm;
   logic [5:0]    w_head_addr;
   logic [31:0]   w_head_wdata;
   logic [5:0]    w_head_tag;
   logic          w_head_io;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_issue_go;
   logic [CW-1:0] w_count_nxt;

   // Entry layout: {we, wmask, addr, wdata, tag}
   assign w_head       = r_mem[r_rd_ptr];
   assign w_head_we    = w_head[48];
   assign w_head_wm    = w_head[47:44];
   assign w_head_addr  = w_head[43:38];
   assign w_head_wdata = w_head[37:6];
   assign w_head_tag   = w_head[5:0];

   // SPI data and GPIO registers must not be touched while a sequence runs
   assign w_head_io = ~w_head_addr[4] &&
                      ((w_head_addr[2:0] == 3'd4) || (w_head_addr[2:0] == 3'd5));

   assign w_empty = (r_count == '0);
   assign w_push  = i_req_valid && r_req_ready;

   assign w_issue_go = !w_empty &&
                       (((r_state == StIdle) && !(w_head_io && i_cr_io_busy)) ||
                        ((r_state == StWaitIo) && !i_cr_io_busy));

`ifdef CTRL_REG_BRIDGE_TIMEOUT_EN
   logic [7:0] r_to_cnt;
   logic       r_rsp_err;
   logic       w_timeout;

   assign w_timeout = (r_state == StWaitIo) && i_cr_io_busy && (r_to_cnt == 8'd254);
   assign w_pop     = w_issue_go || w_timeout;
   assign o_rsp_err = r_rsp_err;
`else
   assign w_pop     = w_issue_go;
   assign o_rsp_err = 1'b0;
`endif

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_req_we, i_req_wmask, i_req_addr, i_req_wdata, i_req_tag};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_req_ready <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count     <= w_count_nxt;
         r_req_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cr_ce_n   <= 1'b1;
         r_cr_we_n   <= 1'b1;
         r_cr_wm     <= '0;
         r_cr_addr   <= '0;
         r_cr_wdata  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_tag   <= '0;
         r_rsp_data  <= '0;
         r_cur_we    <= 1'b0;
         r_cur_tag   <= '0;
`ifdef CTRL_REG_BRIDGE_TIMEOUT_EN
         r_to_cnt    <= '0;
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         r_cr_ce_n   <= 1'b1;
         r_cr_we_n   <= 1'b1;
         r_cr_wm     <= '0;
         r_cr_addr   <= '0;
         r_cr_wdata  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_tag   <= '0;
         r_rsp_data  <= '0;
`ifdef CTRL_REG_BRIDGE_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
`endif
         unique case (r_state)
            StIdle: begin
               if (!w_empty) begin
                  r_state <= StWaitIo;
`ifdef CTRL_REG_BRIDGE_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end
            StWaitIo: begin
`ifdef CTRL_REG_BRIDGE_TIMEOUT_EN
               if (i_cr_io_busy) begin
                  r_to_cnt <= r_to_cnt + 8'd1;
               end
               if (w_timeout) begin
                  r_state     <= StIdle;
                  r_rsp_valid <= 1'b1;
                  r_rsp_tag   <= w_head_tag;
                  r_rsp_err   <= 1'b1;
               end
`endif
            end
            StIssue: begin
               if (r_cur_we) begin
                  r_state     <= StIdle;
                  r_rsp_valid <= 1'b1;
                  r_rsp_tag   <= r_cur_tag;
               end else begin
                  r_state <= StRd1;
               end
            end
            StRd1: begin
               r_state <= StRd2;
            end
            StRd2: begin
               r_state     <= StIdle;
               r_rsp_valid <= 1'b1;
               r_rsp_tag   <= r_cur_tag;
               r_rsp_data  <= i_cr_rdata;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase

         // Issue overrides the idle/wait transitions; port controls are registered here
         if (w_issue_go) begin
            r_state    <= StIssue;
            r_cr_ce_n  <= 1'b0;
            r_cr_we_n  <= ~w_head_we;
            r_cr_wm    <= w_head_wm;
            r_cr_addr  <= w_head_addr;
            r_cr_wdata <= w_head_wdata;
            r_cur_we   <= w_head_we;
            r_cur_tag  <= w_head_tag;
         end
      end
   end

   assign o_req_ready = r_req_ready;
   assign o_cr_ce_n   = r_cr_ce_n;
   assign o_cr_we_n   = r_cr_we_n;
   assign o_cr_wm     = r_cr_wm;
   assign o_cr_addr   = r_cr_addr;
   assign o_cr_wdata  = r_cr_wdata;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_tag   = r_rsp_tag;
   assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_ctrl_reg_bridge.sv
// Scoreboard bench for ctrl_reg_bridge: an in-order register-file model predicts responses and
// port issues; a device model answers loads two cycles after issue.
`timescale 1ns/1ps
module tb_ctrl_reg_bridge;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [3:0]  i_req_wmask;
   logic [5:0]  i_req_addr;
   logic [31:0] i_req_wdata;
   logic [5:0]  i_req_tag;
   logic        o_cr_ce_n;
   logic        o_cr_we_n;
   logic [3:0]  o_cr_wm;
   logic [5:0]  o_cr_addr;
   logic [31:0] o_cr_wdata;
   logic [31:0] i_cr_rdata;
   logic        i_cr_io_busy;
   logic        o_rsp_valid;
   logic [5:0]  o_rsp_tag;
   logic [31:0] o_rsp_data;
   logic        o_rsp_err;

   always #5 clk = ~clk;

   ctrl_reg_bridge #(.FIFO_DEPTH(DEPTH)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_we     (i_req_we),
      .i_req_wmask  (i_req_wmask),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .i_req_tag    (i_req_tag),
      .o_cr_ce_n    (o_cr_ce_n),
      .o_cr_we_n    (o_cr_we_n),
      .o_cr_wm      (o_cr_wm),
      .o_cr_addr    (o_cr_addr),
      .o_cr_wdata   (o_cr_wdata),
      .i_cr_rdata   (i_cr_rdata),
      .i_cr_io_busy (i_cr_io_busy),
      .o_rsp_valid  (o_rsp_valid),
      .o_rsp_tag    (o_rsp_tag),
      .o_rsp_data   (o_rsp_data),
      .o_rsp_err    (o_rsp_err)
   );

   typedef struct {
      logic [5:0]  tag;
      logic [31:0] data;
      logic        err;
      int          lat;
      int          acc;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [3:0]  wm;
      logic [5:0]  addr;
      logic [31:0] wd;
   } iss_t;

   rsp_t        exp_q[$];
   iss_t        iss_q[$];
   logic [31:0] model_regs [64];
   logic [31:0] dev_regs [64];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          mon_en = 0;
   bit          rand_busy = 0;
   logic        busy_prev = 1'b0;
   logic        prev_ce_n = 1'b1;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic bit io_sens(input logic [5:0] a);
      return !a[4] && (a[2:0] == 3'd4 || a[2:0] == 3'd5);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a response or a port access
   initial begin : monitor
      rsp_t e;
      iss_t s;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (o_rsp_valid) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: tag 0x%0h appeared, none expected", o_rsp_tag);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_tag", 32'(o_rsp_tag), 32'(e.tag));
                  check("rsp_data", o_rsp_data, e.data);
                  check("rsp_err", 32'(o_rsp_err), 32'(e.err));
                  if (e.lat != 0) check("rsp_latency", cyc - e.acc, e.lat);
               end
            end
            if (!o_cr_ce_n) begin
               check("issue_single_cycle", 32'(prev_ce_n), 32'd1);
               if (io_sens(o_cr_addr)) check("issue_while_busy", 32'(busy_prev), 32'd0);
               if (iss_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_issue: addr 0x%0h issued, none expected", o_cr_addr);
               end else begin
                  s = iss_q.pop_front();
                  check("issue_we_n", 32'(o_cr_we_n), 32'(!s.we));
                  check("issue_wm", 32'(o_cr_wm), 32'(s.wm));
                  check("issue_addr", 32'(o_cr_addr), 32'(s.addr));
                  check("issue_wdata", o_cr_wdata, s.wd);
               end
            end else begin
               check("idle_we_n", 32'(o_cr_we_n), 32'd1);
               check("idle_wm_addr", {22'd0, o_cr_wm, o_cr_addr}, 32'd0);
               check("idle_wdata", o_cr_wdata, 32'd0);
            end
            prev_ce_n = o_cr_ce_n;
            busy_prev = i_cr_io_busy;
         end
      end
   end

   // Register device: applies stores, returns load data only in the second cycle after issue
   initial begin : device
      int         phase;
      logic [5:0] rd_addr;
      phase = 0;
      rd_addr = '0;
      forever begin
         @(negedge clk);
         if (o_cr_ce_n === 1'b0) begin
            if (!o_cr_we_n) begin
               dev_regs[o_cr_addr] = merge(dev_regs[o_cr_addr], o_cr_wdata, o_cr_wm);
            end else begin
               rd_addr = o_cr_addr;
               phase = 2;
            end
         end
         @(posedge clk);
         #1;
         if (phase == 1) i_cr_rdata = dev_regs[rd_addr];
         else i_cr_rdata = $urandom;
         if (phase > 0) phase--;
      end
   end

   initial begin : busy_gen
      forever begin
         @(posedge clk);
         #1;
         if (rand_busy) i_cr_io_busy = ($urandom_range(0, 3) == 0);
      end
   end

   // All driver tasks start and end just after a rising edge
   task automatic push_req(input logic we, input logic [3:0] wm, input logic [5:0] addr,
                           input logic [31:0] wd, input logic [5:0] tag, input int lat,
                           input bit issues);
      rsp_t e;
      iss_t s;
      bit   done;
      done = 0;
      #1;
      i_req_valid = 1'b1;
      i_req_we    = we;
      i_req_wmask = wm;
      i_req_addr  = addr;
      i_req_wdata = wd;
      i_req_tag   = tag;
      for (int k = 0; k < 600 && !done; k++) begin
         @(negedge clk);
         if (o_req_ready) begin
            e.tag = tag;
            e.err = !issues;
            e.lat = lat;
            e.acc = cyc + 1;
            if (!issues || we) e.data = 32'd0;
            else e.data = model_regs[addr];
            if (issues && we) model_regs[addr] = merge(model_regs[addr], wd, wm);
            exp_q.push_back(e);
            if (issues) begin
               s.we = we;
               s.wm = wm;
               s.addr = addr;
               s.wd = wd;
               iss_q.push_back(s);
            end
            done = 1;
         end
         @(posedge clk);
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: tag 0x%0h not accepted, expected acceptance", tag);
         i_req_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      #1;
      i_req_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic set_busy(input logic b);
      #1;
      i_req_valid = 1'b0;
      i_cr_io_busy = b;
      @(posedge clk);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      #1;
      i_req_valid = 1'b0;
      while ((exp_q.size() != 0 || iss_q.size() != 0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      check("drain_outstanding", exp_q.size() + iss_q.size(), 32'd0);
      @(posedge clk);
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      i_req_valid = 1'b0;
      exp_q.delete();
      iss_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready_low", 32'(o_req_ready), 32'd0);
      check("rst_ce_n", 32'(o_cr_ce_n), 32'd1);
      check("rst_we_n", 32'(o_cr_we_n), 32'd1);
      check("rst_rsp_valid_err", {30'd0, o_rsp_valid, o_rsp_err}, 32'd0);
      check("rst_rsp_tag_data", o_rsp_data | 32'(o_rsp_tag), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_ready_high", 32'(o_req_ready), 32'd1);
      @(posedge clk);
   endtask

   initial begin : driver
      logic [31:0] v;
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         model_regs[i] = v;
         dev_regs[i] = v;
      end
      model_regs[0] = 32'h1234_5678;
      dev_regs[0]   = 32'h1234_5678;
      rst = 1'b1;
      i_req_valid = 1'b0;
      i_req_we = 1'b0;
      i_req_wmask = '0;
      i_req_addr = '0;
      i_req_wdata = '0;
      i_req_tag = '0;
      i_cr_io_busy = 1'b0;
      i_cr_rdata = '0;
      @(posedge clk);
      do_reset();
      mon_en = 1;

      // Idle load: response 4 cycles after acceptance; idle store: 2 cycles
      push_req(1'b0, 4'h0, 6'h00, 32'd0, 6'h01, 4, 1);
      drain(50);
      push_req(1'b1, 4'h5, 6'h01, 32'hA1B2_C3D4, 6'h02, 2, 1);
      drain(50);

      // GPIO store held off by busy for 10 cycles
      set_busy(1'b1);
      push_req(1'b1, 4'hF, 6'h04, 32'hDEAD_BEEF, 6'h03, 0, 1);
      #1;
      i_req_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("ce_n_held_busy", 32'(o_cr_ce_n), 32'd1);
      end
      @(posedge clk);
      #1;
      i_cr_io_busy = 1'b0;
      @(negedge clk);
      check("ce_n_before_issue", 32'(o_cr_ce_n), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("ce_n_issue", 32'(o_cr_ce_n), 32'd0);
      check("we_n_issue", 32'(o_cr_we_n), 32'd0);
      @(posedge clk);
      drain(20);

      // Counter-space load ignores busy
      set_busy(1'b1);
      push_req(1'b0, 4'h0, 6'h10, 32'd0, 6'h04, 4, 1);
      drain(20);

      // Blocked head fills the queue; fifth request waits
      set_busy(1'b1);
      push_req(1'b1, 4'h3, 6'h05, 32'h0101_0202, 6'h05, 0, 1);
      push_req(1'b0, 4'h0, 6'h02, 32'd0, 6'h06, 0, 1);
      push_req(1'b1, 4'hC, 6'h0C, 32'h5555_AAAA, 6'h07, 0, 1);
      push_req(1'b0, 4'h1, 6'h05, 32'd0, 6'h08, 0, 1);
      fork
         push_req(1'b1, 4'hF, 6'h21, 32'h0BAD_F00D, 6'h09, 0, 1);
         begin
            repeat (5) begin
               @(negedge clk);
               check("ready_full", 32'(o_req_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            i_cr_io_busy = 1'b0;
         end
      join
      drain(100);

      // Reset while a load is in RD1 with two more queued
      push_req(1'b0, 4'h0, 6'h03, 32'd0, 6'h0A, 0, 1);
      push_req(1'b0, 4'h0, 6'h06, 32'd0, 6'h0B, 0, 1);
      push_req(1'b0, 4'h0, 6'h08, 32'd0, 6'h0C, 0, 1);
      do_reset();
      repeat (6) begin
         @(negedge clk);
         check("no_rsp_after_reset", 32'(o_rsp_valid), 32'd0);
      end
      @(posedge clk);
      push_req(1'b0, 4'h0, 6'h07, 32'd0, 6'h0D, 4, 1);
      drain(20);

`ifdef CTRL_REG_BRIDGE_TIMEOUT_EN
      set_busy(1'b1);
      push_req(1'b1, 4'hF, 6'h05, 32'h7777_7777, 6'h0E, 256, 0);
      drain(400);
      set_busy(1'b0);
`endif

      // Randomised traffic with random busy
      rand_busy = 1;
      for (int i = 0; i < 200; i++) begin
         push_req(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom), $urandom,
                  6'(i), 0, 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      rand_busy = 0;
      set_busy(1'b0);
      drain(500);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ctrl_reg_bridge.md
CTRL_REG_BRIDGE -- requirements
Module: ctrl_reg_bridge

Interface
REQ-001 Clock clk; reset rst, synchronous, active-high.
REQ-002 Parameter FIFO_DEPTH, default 4, request queue entries (power of two, 2..16).
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  load/store request present.
REQ-006 req_ready  out  1  queue can accept (not full).
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_wmask  in  4  byte enables for stores.
REQ-009 req_addr  in  6  control-register word address.
REQ-010 req_wdata  in  32  store data.
REQ-011 req_tag  in  6  opaque tag returned with response.
REQ-012 cr_ce_n, cr_we_n  out  1 each  register-port enable / write enable, active-low.
REQ-013 cr_wm  out  4; cr_addr  out  6; cr_wdata  out  32: register-port controls.
REQ-014 cr_rdata  in  32  register-port read data.
REQ-015 cr_io_busy  in  1  SPI/GPIO sequence in progress.
REQ-016 rsp_valid  out  1; rsp_tag  out  6; rsp_data  out  32; rsp_err  out  1: one-cycle response pulse, no backpressure.

Function
REQ-017 Request accepted on cycle where req_valid && req_ready; pushed into FIFO in order.
REQ-018 req_ready = FIFO not full; accept and pop in same cycle on a full FIFO not allowed (ready low when full).
REQ-019 FSM states IDLE, WAIT_IO, ISSUE, RD1, RD2.
REQ-020 IDLE: FIFO non-empty -> WAIT_IO if head is I/O-sensitive and cr_io_busy=1, else ISSUE.
REQ-021 I/O-sensitive: cr_addr[4]=0 and cr_addr[2:0] in {4,5} (SPI data, GPIO).
REQ-022 WAIT_IO: stays while cr_io_busy=1; -> ISSUE first cycle cr_io_busy=0.
REQ-023 ISSUE: for exactly one cycle cr_ce_n=0, cr_we_n=~req_we, cr_wm/cr_addr/cr_wdata from head; head popped.
REQ-024 Store: ISSUE -> IDLE; rsp_valid=1 the following cycle with rsp_data=0, rsp_err=0.
REQ-025 Load: ISSUE -> RD1 -> RD2; cr_rdata sampled at end of RD2 (2 cycles after ISSUE); rsp_valid next cycle with sampled data.
REQ-026 Outside ISSUE: cr_ce_n=1, cr_we_n=1, cr_wm=0, cr_addr=0, cr_wdata=0.
REQ-027 Store with cr_wm=0 still issued and responded.
REQ-028 At most one request in flight; back-to-back stores: ISSUE every 2 cycles minimum.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-030 rsp_tag equals tag of completing request; responses in issue order.

Reset
REQ-031 rst: FSM=IDLE, FIFO empty, req_ready=0 during reset cycle and 1 the next cycle, rsp_valid=0, rsp_err=0, cr_ce_n=1, cr_we_n=1, other outputs 0.
REQ-032 rst mid-operation discards queued and in-flight requests; no response emitted for them.

Configuration
REQ-033 Macro CTRL_REG_BRIDGE_TIMEOUT_EN: when defined, 8-bit counter runs in WAIT_IO; on reaching 255 request is popped without issue, rsp_valid=1, rsp_err=1, rsp_data=0, FSM -> IDLE.
REQ-034 Counter clears on WAIT_IO entry and on reset.
REQ-035 Macro undefined: WAIT_IO waits indefinitely, rsp_err tied 0, no counter logic.

Verification
REQ-036 Load addr 0x00, cr_rdata=0x12345678 two cycles after ISSUE -> rsp_valid with data 0x12345678, tag matches, 4 cycles after acceptance.
REQ-037 Store addr 0x04 wmask 0xF while cr_io_busy=1 for 10 cycles -> cr_ce_n stays 1 until busy drops, then one-cycle ISSUE with cr_we_n=0.
REQ-038 Push 5 requests with FIFO_DEPTH=4 and head blocked -> req_ready=0 after 4th, 5th held, all complete in order once unblocked.
REQ-039 Load addr 0x10 (counter space) while cr_io_busy=1 -> issued immediately, no WAIT_IO.
REQ-040 Assert rst during RD1 with 2 queued -> no responses, req_ready=1 one cycle after reset release, new load completes normally.
REQ-041 With CTRL_REG_BRIDGE_TIMEOUT_EN and cr_io_busy held 1 on addr 0x05 store -> rsp_err=1 after 255 cycles in WAIT_IO, cr_ce_n never low.
